// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: scans a 4x3 matrix keypad (0-9, '*', '#'), debounces
// presses and releases, and emits one key code per debounced press.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat pulses while a key is held).
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   col_in     keypad columns, active-low, asynchronous to clk
//   row_out    keypad row drive, active-low one-hot
//   key_code   decoded key (0-9, 10='*', 11='#'); holds the last value
//   key_valid  1-clk pulse, key_code valid in the same cycle
//   key_held   high while a debounced key is held down
module keypad_scan_decoder #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W  = 4;
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SCANS);
`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_TARGET = REP_W'(REPEAT_SCANS);
`endif

  // Reject unusable parameter combinations at elaboration.
  if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1)
  begin : g_param_check
    $error("keypad_scan_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [2:0]        col_m, col_s;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [DB_W-1:0]   db_cnt, db_d;
  logic [1:0]        key_row, key_row_d;
  logic [1:0]        key_col, key_col_d;
  logic [3:0]        row_d;
  logic [3:0]        code_d;
  logic              valid_d;
  logic              held_d;
  logic              one_low;
  logic              all_high;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;
  logic [3:0]        row_rot;
`ifdef KEY_REPEAT_EN
  logic [REP_W-1:0]  rep_cnt, rep_d;
`endif

  // Map a (row, column) position to its key code.
  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] r4;
    logic [3:0] code;
    r4 = {2'b00, r};
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'd10;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = r4 + r4 + r4 + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  // Two-flop synchroniser; idle columns read high through the pull-ups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 3'b111;
      col_s <= 3'b111;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  // Scan tick divider.
  assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Column pattern classification and current row index.
  always_comb begin
    one_low = 1'b1;
    col_idx = 2'd0;
    case (col_s)
      3'b110:  col_idx = 2'd0;
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: one_low = 1'b0;
    endcase
    all_high = (col_s == 3'b111);
    case (row_out)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign row_rot = {row_out[2:0], row_out[3]};

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_out   <= 4'b1110;
      db_cnt    <= '0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      row_out   <= row_d;
      db_cnt    <= db_d;
      key_row   <= key_row_d;
      key_col   <= key_col_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= rep_d;
`endif
    end
  end

  // Next-state and output logic; everything holds between ticks.
  always_comb begin
    state_d   = state;
    row_d     = row_out;
    db_d      = db_cnt;
    key_row_d = key_row;
    key_col_d = key_col;
    code_d    = key_code;
    valid_d   = 1'b0;
    held_d    = key_held;
`ifdef KEY_REPEAT_EN
    rep_d     = rep_cnt;
`endif
    if (tick) begin
      case (state)
        SCAN: begin
          // Zero or multiple low columns (ghosting) keep the scan moving.
          if (one_low) begin
            key_row_d = row_idx;
            key_col_d = col_idx;
            if (DEBOUNCE_SCANS == 1) begin
              code_d  = decode(row_idx, col_idx);
              valid_d = 1'b1;
              held_d  = 1'b1;
              db_d    = '0;
              state_d = PRESSED;
            end else begin
              db_d    = DB_W'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            row_d = row_rot;
          end
        end
        DEBOUNCE: begin
          if (one_low && (col_idx == key_col)) begin
            db_d = db_cnt + DB_W'(1);
            if ((db_cnt + DB_W'(1)) == DB_TARGET) begin
              code_d  = decode(key_row, key_col);
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = PRESSED;
            end
          end else begin
            db_d    = '0;
            row_d   = row_rot;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          // Anything but all-high (including a second key) counts as still pressed.
          if (all_high) begin
            if (DEBOUNCE_SCANS == 1) begin
              held_d  = 1'b0;
              db_d    = '0;
              row_d   = row_rot;
              state_d = SCAN;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end else begin
              db_d    = DB_W'(1);
              state_d = RELEASE;
            end
          end else begin
`ifdef KEY_REPEAT_EN
            if ((rep_cnt + REP_W'(1)) == REP_TARGET) begin
              valid_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d   = rep_cnt + REP_W'(1);
            end
`endif
          end
        end
        RELEASE: begin
          if (all_high) begin
            db_d = db_cnt + DB_W'(1);
            if ((db_cnt + DB_W'(1)) == DB_TARGET) begin
              held_d  = 1'b0;
              db_d    = '0;
              row_d   = row_rot;
              state_d = SCAN;
`ifdef KEY_REPEAT_EN
              rep_d   = '0;
`endif
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder: self-checking bench for keypad_scan_decoder
// (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=10). A behavioural keypad
// pulls a column low only while its row is driven; key_valid pulses are
// logged and matched against a queue of expected codes.
module tb_keypad_scan_decoder;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 3;
  localparam int unsigned REP      = 10;
`ifdef KEY_REPEAT_EN
  localparam int HOLD_PULSES = 3;
`else
  localparam int HOLD_PULSES = 1;
`endif

  typedef struct {
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] code;
  } key_vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       press_en = 1'b0;
  logic [1:0] press_row = 2'd0;
  logic [1:0] press_col = 2'd0;
  logic       force_en = 1'b0;
  logic [2:0] force_val = 3'b111;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0] obs_code [256];
  int         obs_cyc  [256];
  int         obs_n = 0;
  int         rd = 0;
  logic [3:0] exp_q [$];

  key_vec_t   vecs [12];
  logic [3:0] row_pat [4];

  keypad_scan_decoder #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse logger.
  always @(negedge clk) begin
    if (rst_n && key_valid && obs_n < 256) begin
      obs_code[obs_n] <= key_code;
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
  end

  // Keypad model.
  always_comb begin
    col_in = 3'b111;
    if (force_en) begin
      col_in = force_val;
    end else if (press_en && (row_out[press_row] == 1'b0)) begin
      col_in[press_col] = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", nm, act, req);
    end
  endtask

  task automatic drain();
    logic [3:0] e;
    while (rd < obs_n) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_pulse act=%0d req=none", obs_code[rd]);
      end else begin
        e = exp_q.pop_front();
        chk("sb_key_code", 32'(obs_code[rd]), 32'(e));
      end
      rd++;
    end
  endtask

  task automatic wait_held(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (key_held !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(key_held), 32'(lvl));
  endtask

  // Returns at the first negedge after row_out has just switched to r.
  task automatic wait_row(input logic [3:0] r, input string nm);
    int n;
    n = 0;
    while (row_out == r && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (row_out != r && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(row_out), 32'(r));
  endtask

  initial begin
    int start;
    logic [3:0] prev;

    vecs[0]  = '{2'd0, 2'd0, 4'd1};
    vecs[1]  = '{2'd0, 2'd1, 4'd2};
    vecs[2]  = '{2'd0, 2'd2, 4'd3};
    vecs[3]  = '{2'd1, 2'd0, 4'd4};
    vecs[4]  = '{2'd1, 2'd1, 4'd5};
    vecs[5]  = '{2'd1, 2'd2, 4'd6};
    vecs[6]  = '{2'd2, 2'd0, 4'd7};
    vecs[7]  = '{2'd2, 2'd1, 4'd8};
    vecs[8]  = '{2'd2, 2'd2, 4'd9};
    vecs[9]  = '{2'd3, 2'd0, 4'd10};
    vecs[10] = '{2'd3, 2'd1, 4'd0};
    vecs[11] = '{2'd3, 2'd2, 4'd11};
    row_pat[0] = 4'b1110;
    row_pat[1] = 4'b1101;
    row_pat[2] = 4'b1011;
    row_pat[3] = 4'b0111;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_row", 32'(row_out), 32'(4'b1110));
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of the scan.
    wait_row(4'b1011, "scan_reach_row2");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_row", 32'(row_out), 32'(4'b1110));
    chk("async_rst_code", 32'(key_code), 32'd0);
    chk("async_rst_valid", 32'(key_valid), 32'd0);
    chk("async_rst_held", 32'(key_held), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Press '5': exact latency, single pulse, row frozen.
    press_row = 2'd1;
    press_col = 2'd1;
    wait_row(4'b1101, "p5_reach_row1");
    exp_q.push_back(4'd5);
    press_en = 1'b1;
    repeat (12) @(negedge clk);
    chk("p5_valid", 32'(key_valid), 32'd1);
    chk("p5_code", 32'(key_code), 32'd5);
    chk("p5_held", 32'(key_held), 32'd1);
    @(negedge clk);
    chk("p5_valid_one_clk", 32'(key_valid), 32'd0);
    chk("p5_row_frozen", 32'(row_out), 32'(4'b1101));
    repeat (6 * SCAN_DIV) @(negedge clk);
    chk("p5_row_still_frozen", 32'(row_out), 32'(4'b1101));
    chk("p5_still_held", 32'(key_held), 32'd1);
    press_en = 1'b0;
    wait_held(1'b0, 100, "p5_release");
    @(negedge clk);
    drain();

    // Every key of the pad.
    for (int i = 0; i < 12; i++) begin
      press_row = vecs[i].row;
      press_col = vecs[i].col;
      exp_q.push_back(vecs[i].code);
      press_en = 1'b1;
      wait_held(1'b1, 200, "tbl_held");
      chk("tbl_row", 32'(row_out), 32'(row_pat[vecs[i].row]));
      chk("tbl_code", 32'(key_code), 32'(vecs[i].code));
      press_en = 1'b0;
      wait_held(1'b0, 200, "tbl_release");
      @(negedge clk);
      drain();
    end

    // Bounce: column low for only two ticks.
    start = obs_n;
    press_row = 2'd1;
    press_col = 2'd1;
    wait_row(4'b1101, "bounce_reach_row1");
    press_en = 1'b1;
    repeat (8) @(negedge clk);
    press_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("bounce_row_resumes", 32'(row_out), 32'(4'b1011));
    chk("bounce_held", 32'(key_held), 32'd0);
    repeat (8) @(negedge clk);
    chk("bounce_no_valid", 32'(obs_n - start), 32'd0);

    // Ghosting: two columns low never freezes the scan.
    start = obs_n;
    force_val = 3'b100;
    force_en = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      prev = row_out;
      repeat (SCAN_DIV) @(negedge clk);
      chk("ghost_rotate", 32'(row_out), 32'({prev[2:0], prev[3]}));
    end
    force_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("ghost_no_valid", 32'(obs_n - start), 32'd0);

    // Release bounce on '#'.
    start = obs_n;
    press_row = 2'd3;
    press_col = 2'd2;
    exp_q.push_back(4'd11);
    press_en = 1'b1;
    wait_held(1'b1, 200, "hash_held");
    press_en = 1'b0;
    repeat (8) @(negedge clk);
    press_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("hash_bounce_held", 32'(key_held), 32'd1);
    press_en = 1'b0;
    repeat (8) @(negedge clk);
    chk("hash_held_two_high", 32'(key_held), 32'd1);
    repeat (4) @(negedge clk);
    chk("hash_held_drop", 32'(key_held), 32'd0);
    chk("hash_row_rotate", 32'(row_out), 32'(4'b1110));
    @(negedge clk);
    chk("hash_one_pulse", 32'(obs_n - start), 32'd1);
    drain();

    // Long hold of '0'.
    start = obs_n;
    press_row = 2'd3;
    press_col = 2'd1;
    exp_q.push_back(4'd0);
`ifdef KEY_REPEAT_EN
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
`endif
    press_en = 1'b1;
    wait_held(1'b1, 200, "zero_held");
    repeat (25 * SCAN_DIV) @(negedge clk);
    press_en = 1'b0;
    wait_held(1'b0, 200, "zero_release");
    @(negedge clk);
    chk("zero_pulse_count", 32'(obs_n - start), 32'(HOLD_PULSES));
`ifdef KEY_REPEAT_EN
    chk("zero_repeat_gap1", 32'(obs_cyc[start + 1] - obs_cyc[start]), 32'(REP * SCAN_DIV));
    chk("zero_repeat_gap2", 32'(obs_cyc[start + 2] - obs_cyc[start + 1]), 32'(REP * SCAN_DIV));
`endif
    drain();

    // Reset while '8' is held, then fresh detection.
    press_row = 2'd2;
    press_col = 2'd1;
    exp_q.push_back(4'd8);
    press_en = 1'b1;
    wait_held(1'b1, 200, "mid_held");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_row", 32'(row_out), 32'(4'b1110));
    chk("mid_rst_code", 32'(key_code), 32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_held", 32'(key_held), 32'd0);
    exp_q.push_back(4'd8);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_held(1'b1, 200, "mid_redetect");
    chk("mid_redetect_code", 32'(key_code), 32'd8);
    press_en = 1'b0;
    wait_held(1'b0, 200, "mid_release");

    repeat (4) @(negedge clk);
    drain();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
